// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared constants and helpers for the instruction-fetch stage
//
// Purpose: default widths/step/depth used by fetch_unit, fetch_queue and
// fetch_unit_if, plus the credit test that gates ROM requests.
// Ports: none (package).
package fetch_unit_pkg;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  localparam int DEF_PC_WIDTH    = 32;
  localparam int DEF_INST_WIDTH  = 32;
  localparam int DEF_PC_STEP     = 4;
  localparam int DEF_QUEUE_DEPTH = 4;

  // A request may only be issued if its response is guaranteed a queue slot:
  // entries already held plus the one read still in flight must leave room.
  function automatic logic has_credit(input logic [31:0] occupied,
                                      input int unsigned depth);
    return occupied < depth;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - ROM request port and decode handshake of the fetch stage
//
// Purpose: bundles the instruction-ROM port and the fetch->decode stream.
// Ports (master = fetch stage side):
//   rom_ce     out  ROM chip enable (fetch request this cycle)
//   rom_addr   out  ROM read address
//   rom_data   in   ROM read data, one cycle after rom_ce
//   inst_valid out  queue head holds a valid instruction
//   inst_ready in   decode accepts the head this cycle
//   inst_data  out  instruction at queue head
//   inst_pc    out  PC of the instruction at queue head
interface fetch_unit_if
  import fetch_unit_pkg::*;
#(
  parameter int PC_WIDTH   = DEF_PC_WIDTH,
  parameter int INST_WIDTH = DEF_INST_WIDTH
);

  logic                  rom_ce;
  logic [PC_WIDTH-1:0]   rom_addr;
  logic [INST_WIDTH-1:0] rom_data;
  logic                  inst_valid;
  logic                  inst_ready;
  logic [INST_WIDTH-1:0] inst_data;
  logic [PC_WIDTH-1:0]   inst_pc;

  modport master (
    output rom_ce, rom_addr, inst_valid, inst_data, inst_pc,
    input  rom_data, inst_ready
  );

  modport slave (
    input  rom_ce, rom_addr, inst_valid, inst_data, inst_pc,
    output rom_data, inst_ready
  );

endinterface

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - prefetch FIFO holding {instruction, pc} entries
//
// Purpose: synchronous FIFO with flush; head entry is always driven.
// Ports:
//   clk      in   clock
//   rst      in   asynchronous active-high reset
//   push_i   in   write data_i at tail
//   data_i   in   entry to write
//   pop_i    in   drop head entry (ignored when empty)
//   flush_i  in   discard all entries (wins over push/pop)
//   data_o   out  head entry
//   count_o  out  number of entries held
module fetch_queue
  import fetch_unit_pkg::*;
#(
  parameter int DEPTH = DEF_QUEUE_DEPTH,
  parameter int WIDTH = DEF_INST_WIDTH + DEF_PC_WIDTH,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [WIDTH-1:0] data_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [CW-1:0]    count_q;
  logic             do_pop;

  assign do_pop  = pop_i && (count_q != '0);
  assign data_o  = mem_q[rd_q];
  assign count_o = count_q;

  // Storage is cleared on reset so the head output is never X.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_q] <= data_i;
        wr_q        <= wr_q + AW'(1);
      end
      if (do_pop) rd_q <= rd_q + AW'(1);
      count_q <= count_q + CW'(push_i) - CW'(do_pop);
    end
  end

  // The fetch credit rule must keep every response within capacity.
  a_no_overflow : assert property (@(posedge clk) disable iff (rst)
    !(push_i && !flush_i && (count_q == CW'(DEPTH))));

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC generator, ROM request port and prefetch queue to decode
//
// Purpose: issues sequential fetches to a 1-cycle-latency ROM, buffers the
// returned words with their PCs, and presents them to decode with
// valid/ready back-pressure. A redirect reloads the PC and flushes
// everything fetched so far, including a read still in flight.
// Ports:
//   clk          in   clock
//   rst          in   asynchronous active-high reset
//   redirect_i   in   taken branch/jump from a later stage
//   redirect_pc  in   redirect target
//   bus          -    fetch_unit_if.master (ROM port + decode stream)
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int                  PC_WIDTH    = DEF_PC_WIDTH,
  parameter int                  INST_WIDTH  = DEF_INST_WIDTH,
  parameter int                  PC_STEP     = DEF_PC_STEP,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = '0,
  parameter int                  QUEUE_DEPTH = DEF_QUEUE_DEPTH
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                redirect_i,
  input  logic [PC_WIDTH-1:0] redirect_pc,
  fetch_unit_if.master        bus
);

  localparam int CW = $clog2(QUEUE_DEPTH) + 1;
  localparam int QW = INST_WIDTH + PC_WIDTH;

  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [PC_WIDTH-1:0] req_pc_q, req_pc_d;
  logic                inflight_q, inflight_d;
  logic                issue, push, pop, inst_valid;
  logic [CW-1:0]       count;
  logic [QW-1:0]       head;

  // rst gates the request combinationally so rom_ce drops the moment reset
  // asserts, not at the next edge.
  assign issue = !rst && !redirect_i &&
                 has_credit(32'(count) + 32'(inflight_q), QUEUE_DEPTH);

  // A response arriving in a redirect cycle belongs to the old path.
  assign push       = inflight_q && !redirect_i;
  assign inst_valid = (count != '0);
  assign pop        = inst_valid && bus.inst_ready && !redirect_i;

  always_comb begin
    pc_d       = pc_q;
    req_pc_d   = req_pc_q;
    inflight_d = inflight_q;
    if (redirect_i) begin
      pc_d       = redirect_pc;
      inflight_d = DISABLE;
    end else begin
      inflight_d = issue;
      if (issue) begin
        req_pc_d = pc_q;
        pc_d     = pc_q + PC_WIDTH'(PC_STEP);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      req_pc_q   <= RESET_PC;
      inflight_q <= DISABLE;
    end else begin
      pc_q       <= pc_d;
      req_pc_q   <= req_pc_d;
      inflight_q <= inflight_d;
    end
  end

  fetch_queue #(
    .DEPTH (QUEUE_DEPTH),
    .WIDTH (QW)
  ) u_queue (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .data_i  ({bus.rom_data, req_pc_q}),
    .pop_i   (pop),
    .flush_i (redirect_i),
    .data_o  (head),
    .count_o (count)
  );

  assign bus.rom_ce     = issue;
  assign bus.rom_addr   = pc_q;
  assign bus.inst_valid = inst_valid;
  assign bus.inst_data  = head[QW-1:PC_WIDTH];
  assign bus.inst_pc    = head[PC_WIDTH-1:0];

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_i;
  logic [31:0] redirect_pc;

  always #5 clk = ~clk;

  fetch_unit_if #(.PC_WIDTH(32), .INST_WIDTH(32)) bus ();
  fetch_unit_if #(.PC_WIDTH(32), .INST_WIDTH(32)) wbus ();

  fetch_unit #(
    .PC_WIDTH(32), .INST_WIDTH(32), .PC_STEP(4),
    .RESET_PC(32'h0000_0000), .QUEUE_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst), .redirect_i(redirect_i),
    .redirect_pc(redirect_pc), .bus(bus.master)
  );

  fetch_unit #(
    .PC_WIDTH(32), .INST_WIDTH(32), .PC_STEP(4),
    .RESET_PC(32'hFFFF_FFFC), .QUEUE_DEPTH(4)
  ) u_wrap (
    .clk(clk), .rst(rst), .redirect_i(1'b0),
    .redirect_pc(32'h0), .bus(wbus.master)
  );

  function automatic logic [31:0] rom_fn(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A3C_96E1;
  endfunction

  // Instruction memory: one-cycle read latency.
  always @(posedge clk) begin
    if (bus.rom_ce)  bus.rom_data  <= rom_fn(bus.rom_addr);
    if (wbus.rom_ce) wbus.rom_data <= rom_fn(wbus.rom_addr);
  end
  assign wbus.inst_ready = 1'b0;

  int checks = 0;
  int errors = 0;
  int n_acc  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: after reset or redirect the decode stream is the
  // sequential program starting at the new PC, each word = rom_fn(pc).
  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } exp_t;
  exp_t        exp_q[$];
  logic [31:0] next_pc;

  task automatic refill();
    exp_t e;
    while (exp_q.size() < 8) begin
      e.pc   = next_pc;
      e.data = rom_fn(next_pc);
      exp_q.push_back(e);
      next_pc = next_pc + 32'd4;
    end
  endtask

  task automatic model_restart(input logic [31:0] pc);
    exp_q.delete();
    next_pc = pc;
    refill();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    refill();
  endtask

  // Monitor: every accepted instruction must be the next one of the model.
  always @(negedge clk) begin
    if (!rst && bus.inst_valid && bus.inst_ready && !redirect_i) begin
      n_acc++;
      check("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check("sb_pc", 64'(bus.inst_pc), 64'(e.pc));
        check("sb_data", 64'(bus.inst_data), 64'(e.data));
      end
    end
  end

  initial begin
    int n_issue;
    int acc0;
    rst = 1'b1;
    redirect_i = 1'b0;
    redirect_pc = 32'h0;
    bus.inst_ready = 1'b0;
    model_restart(32'h0);
    repeat (2) tick();

    // Reset release, first fetches and steady stream; wrap instance alongside.
    rst = 1'b0;
    bus.inst_ready = 1'b1;
    @(negedge clk);
    check("t1_ce0", 64'(bus.rom_ce), 64'd1);
    check("t1_addr0", 64'(bus.rom_addr), 64'h0);
    check("t1_valid0", 64'(bus.inst_valid), 64'd0);
    check("t5_wrap_addr0", 64'(wbus.rom_addr), 64'hFFFF_FFFC);
    tick();
    @(negedge clk);
    check("t1_addr1", 64'(bus.rom_addr), 64'h4);
    check("t1_valid1", 64'(bus.inst_valid), 64'd0);
    check("t5_wrap_addr1", 64'(wbus.rom_addr), 64'h0);
    tick();
    @(negedge clk);
    check("t1_valid2", 64'(bus.inst_valid), 64'd1);
    check("t1_pc2", 64'(bus.inst_pc), 64'h0);
    for (int i = 0; i < 6; i++) begin
      tick();
      @(negedge clk);
      check("t1_stream_valid", 64'(bus.inst_valid), 64'd1);
      check("t1_stream_pc", 64'(bus.inst_pc), 64'(4 * (i + 1)));
    end

    // Back-pressure from a fresh reset: exactly QUEUE_DEPTH fetches.
    tick();
    rst = 1'b1;
    bus.inst_ready = 1'b0;
    model_restart(32'h0);
    tick();
    tick();
    rst = 1'b0;
    n_issue = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.rom_ce) n_issue++;
      if (bus.inst_valid) check("t2_hold_pc", 64'(bus.inst_pc), 64'h0);
      tick();
    end
    check("t2_issues", 64'(n_issue), 64'd4);
    @(negedge clk);
    check("t2_ce_off", 64'(bus.rom_ce), 64'd0);
    check("t2_addr", 64'(bus.rom_addr), 64'h10);
    check("t2_valid", 64'(bus.inst_valid), 64'd1);
    tick();
    bus.inst_ready = 1'b1;
    acc0 = n_acc;
    repeat (5) begin
      @(negedge clk);
      tick();
    end
    check("t2_accepts", 64'(n_acc - acc0), 64'd5);

    // Redirect while the queue is full.
    bus.inst_ready = 1'b0;
    repeat (8) tick();
    @(negedge clk);
    check("t3_full_ce", 64'(bus.rom_ce), 64'd0);
    tick();
    redirect_i = 1'b1;
    redirect_pc = 32'h100;
    model_restart(32'h100);
    @(negedge clk);
    check("t3_ce_redirect", 64'(bus.rom_ce), 64'd0);
    tick();
    redirect_i = 1'b0;
    bus.inst_ready = 1'b1;
    @(negedge clk);
    check("t3_addr", 64'(bus.rom_addr), 64'h100);
    check("t3_flushed", 64'(bus.inst_valid), 64'd0);
    tick();
    @(negedge clk);
    check("t3_valid_r1", 64'(bus.inst_valid), 64'd0);
    tick();
    @(negedge clk);
    check("t3_valid_r2", 64'(bus.inst_valid), 64'd1);
    check("t3_pc", 64'(bus.inst_pc), 64'h100);

    // Redirect while the read of 0x20 is in flight.
    tick();
    redirect_i = 1'b1;
    redirect_pc = 32'h20;
    model_restart(32'h20);
    tick();
    redirect_i = 1'b0;
    tick();
    redirect_i = 1'b1;
    redirect_pc = 32'h40;
    model_restart(32'h40);
    @(negedge clk);
    check("t4_ce_off", 64'(bus.rom_ce), 64'd0);
    check("t4_valid", 64'(bus.inst_valid), 64'd0);
    tick();
    redirect_i = 1'b0;
    @(negedge clk);
    check("t4_addr", 64'(bus.rom_addr), 64'h40);
    check("t4_valid_r0", 64'(bus.inst_valid), 64'd0);
    tick();
    @(negedge clk);
    check("t4_valid_r1", 64'(bus.inst_valid), 64'd0);
    tick();
    @(negedge clk);
    check("t4_valid_r2", 64'(bus.inst_valid), 64'd1);
    check("t4_pc", 64'(bus.inst_pc), 64'h40);

    // Asynchronous reset between edges.
    repeat (6) tick();
    check("t6_pre_valid", 64'(bus.inst_valid), 64'd1);
    #2;
    rst = 1'b1;
    model_restart(32'h0);
    #1;
    check("t6_valid", 64'(bus.inst_valid), 64'd0);
    check("t6_ce", 64'(bus.rom_ce), 64'd0);
    check("t6_addr", 64'(bus.rom_addr), 64'h0);
    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("t6_ce_after", 64'(bus.rom_ce), 64'd1);
    tick();
    tick();
    @(negedge clk);
    check("t6_restart_valid", 64'(bus.inst_valid), 64'd1);
    check("t6_restart_pc", 64'(bus.inst_pc), 64'h0);

    // Random back-pressure and redirects, including targets near the wrap.
    acc0 = n_acc;
    for (int i = 0; i < 600; i++) begin
      tick();
      redirect_i = 1'b0;
      bus.inst_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 19) == 0) begin
        redirect_i = 1'b1;
        redirect_pc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0
                                                  : ($urandom & 32'h0000_FFFC);
        model_restart(redirect_pc);
      end
    end
    tick();
    redirect_i = 1'b0;
    check("rand_progress", 64'((n_acc - acc0) > 100), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
